// File: rtl/fifo_2_spi.sv
// SPI mode-0 master that drains the bridge TX FIFO word by word and returns the
// full-duplex receive data to the bridge RX FIFO while the read window is open.
module fifo_2_spi #(
   parameter int DATA_WIDTH = 32,
   parameter int CLK_DIV    = 4
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  empty_tx,
   input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
   output logic                  read_fifo_tx,
   input  logic                  full_rx,
   input  logic                  end_rx,
   output logic                  write_fifo_rx,
   output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  cs_n,
   output logic                  busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, STORE, HOLD} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  div_last;
   logic                  bit_last;

   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign bit_last = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

   // Push strobe is decoded from STORE so it lands on the very cycle the RX FIFO frees up.
   assign write_fifo_rx  = (state == STORE) && !end_rx && !full_rx;
   assign fifo_w_data_rx = write_fifo_rx ? rx_shift : rx_data_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state        <= IDLE;
         sclk         <= 1'b0;
         mosi         <= 1'b0;
         cs_n         <= 1'b1;
         busy         <= 1'b0;
         read_fifo_tx <= 1'b0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         rx_data_q    <= '0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
      end else begin
         read_fifo_tx <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty_tx) begin
                  state        <= LOAD;
                  read_fifo_tx <= 1'b1;
                  cs_n         <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            LOAD: begin
               tx_shift <= fifo_r_data_tx;
               mosi     <= fifo_r_data_tx[DATA_WIDTH-1];
               rx_shift <= '0;
               bit_cnt  <= '0;
               div_cnt  <= '0;
               sclk     <= 1'b0;
               state    <= SETUP;
            end
            SETUP: begin
               mosi <= tx_shift[DATA_WIDTH-1];
               if (div_last) begin
                  div_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk     <= 1'b1;
                     rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                  end else begin
                     sclk     <= 1'b0;
                     tx_shift <= tx_shift << 1;
                     mosi     <= tx_shift[DATA_WIDTH-2];
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_last) state <= STORE;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            STORE: begin
               // Stay here while the RX FIFO is full and the word is still wanted.
               if (end_rx || !full_rx) begin
                  if (!end_rx) rx_data_q <= rx_shift;
                  if (!empty_tx) begin
                     state        <= LOAD;
                     read_fifo_tx <= 1'b1;
                  end else begin
                     state   <= HOLD;
                     div_cnt <= '0;
                  end
               end
            end
            HOLD: begin
               if (div_last) begin
                  div_cnt <= '0;
                  state   <= IDLE;
                  cs_n    <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cs_n  <= 1'b1;
               busy  <= 1'b0;
               sclk  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_2_spi.md
Name: fifo_2_spi

Overview:
- SPI master engine on the far side of the APB-to-FIFO bridge.
- Pops words from the bridge TX FIFO and shifts them out MSB-first in SPI mode 0 (CPOL=0, CPHA=0).
- Captures MISO in parallel and pushes each received word into the bridge RX FIFO, only while the bridge's read-count window is open (end_rx=0).
- One full-duplex word transfer per TX FIFO entry; cs_n stays low across back-to-back words.

Parameters:
DATA_WIDTH, 32, word width of FIFO data and SPI frame length in bits
CLK_DIV, 4, pclk cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV pclk

Ports:
pclk  in  1  system clock
presetn  in  1  reset, asynchronous, active-low
empty_tx  in  1  TX FIFO empty
fifo_r_data_tx  in  DATA_WIDTH  TX FIFO head word (first-word-fall-through, valid when empty_tx=0)
read_fifo_tx  out  1  one-cycle pop strobe for TX FIFO
full_rx  in  1  RX FIFO full
end_rx  in  1  1 = no RX words requested; received words discarded
write_fifo_rx  out  1  one-cycle push strobe for RX FIFO
fifo_w_data_rx  out  DATA_WIDTH  received word, valid with write_fifo_rx
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  1  chip select, active-low
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values:
  - state = IDLE
  - sclk=0, mosi=0, cs_n=1, busy=0
  - read_fifo_tx=0, write_fifo_rx=0, fifo_w_data_rx=0
  - shift registers, divider and bit counters = 0
- Reset mid-transfer aborts immediately. The partial word is lost; no RX push occurs.
- cs_n and busy are registered: cs_n=0 and busy=1 in every state except IDLE.
- States:
  - IDLE: if empty_tx=0 -> LOAD. Otherwise stay.
  - LOAD (1 cycle):
    - read_fifo_tx=1 for exactly this cycle.
    - tx_shift <= fifo_r_data_tx; rx_shift cleared; bit counter cleared.
    - -> SETUP.
  - SETUP (CLK_DIV cycles):
    - sclk=0; mosi = tx_shift[DATA_WIDTH-1].
    - -> SHIFT.
  - SHIFT:
    - Divider counts CLK_DIV cycles per half-period.
    - End of low half: sclk rises; rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso}, with miso sampled in the same pclk cycle.
    - End of high half: sclk falls; tx_shift shifts left one bit (mosi follows the new MSB); bit counter increments.
    - After the DATA_WIDTH-th falling edge -> STORE.
    - Duration is exactly 2*CLK_DIV*DATA_WIDTH cycles.
  - STORE (>=1 cycle, sclk=0):
    - If end_rx=1: discard the word, no push.
    - Else if full_rx=0: write_fifo_rx=1 for one cycle; fifo_w_data_rx = rx_shift.
    - Else (full_rx=1 and end_rx=0): stall in STORE, no strobe, cs_n held low. Leave on the cycle full_rx=0 (push) or end_rx=1 (discard).
    - On exit: if empty_tx=0 -> LOAD (cs_n stays low). Else -> HOLD.
  - HOLD (CLK_DIV cycles, cs_n still low, sclk=0): -> IDLE; cs_n rises on IDLE entry.
- Single isolated word: cs_n low for 1 + CLK_DIV + 2*CLK_DIV*DATA_WIDTH + 1 + CLK_DIV cycles when RX is not full.
- read_fifo_tx is never asserted while empty_tx=1.
- write_fifo_rx is never asserted while full_rx=1 or end_rx=1.
- fifo_w_data_rx holds its last pushed value between pushes.
- empty_tx going 0 during SHIFT/SETUP/HOLD has no effect until STORE or IDLE samples it.
- end_rx is sampled only in STORE; toggling it during SHIFT does not affect the word in flight.
- sclk, mosi and cs_n are direct register outputs (glitch-free).

Test Plan:
1. Single word loopback: DATA_WIDTH=32, CLK_DIV=2, miso tied to mosi, end_rx=0, TX holds 0xA5A50F0F.
   -> Exactly 32 sclk rising edges; read_fifo_tx pulses once; write_fifo_rx pulses once with 0xA5A50F0F; cs_n low for exactly 134 cycles; busy=0 afterwards.
2. Back-to-back: TX holds 0x00000001, 0x80000000, miso=1 constant.
   -> cs_n never rises between words; mosi shows 31 zeros then 1, then 1 then 31 zeros; two RX pushes of 0xFFFFFFFF.
3. RX full stall: full_rx=1 from start of transfer, released 10 cycles after STORE entry.
   -> sclk stays 0 and cs_n low during the stall; write_fifo_rx asserts on the cycle full_rx drops; no push occurs while full_rx=1.
4. Discard: end_rx=1, TX holds 3 words.
   -> 3 complete SPI frames on the pins; zero write_fifo_rx pulses; 3 read_fifo_tx pulses.
5. Reset mid-transfer: assert presetn=0 after 10 sclk edges.
   -> Same cycle: cs_n=1, sclk=0, mosi=0, busy=0; no RX push. After release with empty_tx=1, the block stays IDLE.
6. Divider check: CLK_DIV=1, DATA_WIDTH=8, TX word 0x3C, loopback.
   -> sclk toggles every pclk cycle; 8 rising edges; RX word 0x3C; cs_n low for 1+1+16+1+1 = 20 cycles.
